// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Results are held stable between conversions so downstream 7-segment decoders never flicker.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     shreg_q;
  logic [4*DIGITS-1:0]  scratch_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_int_q;

  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  scratch_nxt;
  logic                 carry;
  logic                 ovf_nxt;
  logic                 zero_run;
  logic [DIGITS-1:0]    blank_nxt;
  logic [4*DIGITS-1:0]  bcd_nxt;

  // One double-dabble step plus the display-ready view of its result.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    {carry, scratch_nxt} = {adj, shreg_q[WIDTH-1]};
    ovf_nxt = ovf_int_q | carry;

    zero_run  = 1'b1;
    blank_nxt = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run     = zero_run & (scratch_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_run;
    end

    if (ovf_nxt) begin
      bcd_nxt   = {DIGITS{4'h9}};
      blank_nxt = '0;
    end else begin
      bcd_nxt = scratch_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      ovf_int_q <= 1'b0;
      bcd       <= '0;
      blank     <= BlankRst;
      ovf       <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            shreg_q   <= bin;
            scratch_q <= '0;
            count_q   <= CW'(WIDTH);
            ovf_int_q <= 1'b0;
            state_q   <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          scratch_q <= scratch_nxt;
          shreg_q   <= shreg_q << 1;
          count_q   <= count_q - CW'(1);
          ovf_int_q <= ovf_nxt;
          if (count_q == CW'(1)) begin
            bcd     <= bcd_nxt;
            blank   <= blank_nxt;
            ovf     <= ovf_nxt;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule
